// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: serialises a word-wide bitstream LSB-first into the CLB chain, then the connection chain.
// Define CFG_CRC_EN to add a trailing CRC-16-CCITT word that is checked against the shifted bits.
module fpga_cfg_loader #(
    parameter int WORD_W         = 32,
    parameter int CLB_CHAIN_LEN  = 1024,
    parameter int CONN_CHAIN_LEN = 4096,
    parameter int CNT_W          = 16
) (
    input  logic              scan_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              clb_scan_en,
    output logic              clb_scan_in,
    output logic              conn_scan_en,
    output logic              conn_scan_in,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int REM_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLB,
        S_CONN,
        S_CRC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic              ready_q, ready_d;
    logic              clb_en_q, clb_en_d;
    logic              clb_in_q, clb_in_d;
    logic              conn_en_q, conn_en_d;
    logic              conn_in_q, conn_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              bit_vld;
    logic              bit_val;
    logic [CNT_W-1:0]  take;
`ifdef CFG_CRC_EN
    logic [15:0]       crc_q, crc_d;
    logic              err_q, err_d;
`endif

    assign accept = cfg_valid & ready_q;

    // rem_q counts bits still waiting in sr_q; left_q counts bits the current chain still needs.
    // Bits of a word beyond left_q are never counted into rem_q, which is how they get discarded.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        left_d  = left_q;
        busy_d  = busy_q;
        done_d  = done_q;
        bit_vld = 1'b0;
        bit_val = 1'b0;
        take    = (left_q >= CNT_W'(WORD_W)) ? CNT_W'(WORD_W) : left_q;
`ifdef CFG_CRC_EN
        crc_d   = crc_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLB;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    sr_d    = '0;
                    rem_d   = '0;
                    left_d  = CNT_W'(CLB_CHAIN_LEN);
`ifdef CFG_CRC_EN
                    crc_d   = 16'hFFFF;
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLB, S_CONN: begin
                if (accept) begin
                    bit_vld = 1'b1;
                    bit_val = cfg_data[0];
                    sr_d    = cfg_data >> 1;
                    rem_d   = REM_W'(take - CNT_W'(1));
                    left_d  = left_q - CNT_W'(1);
                end else if (rem_q != '0) begin
                    bit_vld = 1'b1;
                    bit_val = sr_q[0];
                    sr_d    = sr_q >> 1;
                    rem_d   = rem_q - REM_W'(1);
                    left_d  = left_q - CNT_W'(1);
                end else if (left_q == '0) begin
                    sr_d = '0;
                    if (state_q == S_CLB) begin
                        state_d = S_CONN;
                        left_d  = CNT_W'(CONN_CHAIN_LEN);
                    end else begin
`ifdef CFG_CRC_EN
                        state_d = S_CRC;
`else
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef CFG_CRC_EN
            S_CRC: begin
                if (accept) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = (cfg_data[15:0] != crc_q);
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef CFG_CRC_EN
        if (bit_vld) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_val) ? 16'h1021 : 16'h0000);
        end
`endif
        clb_en_d  = bit_vld && (state_q == S_CLB);
        clb_in_d  = clb_en_d && bit_val;
        conn_en_d = bit_vld && (state_q == S_CONN);
        conn_in_d = conn_en_d && bit_val;
        ready_d   = ((state_d == S_CLB || state_d == S_CONN) && rem_d == '0 && left_d != '0)
                    || (state_d == S_CRC);
    end

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            rem_q     <= '0;
            left_q    <= '0;
            ready_q   <= 1'b0;
            clb_en_q  <= 1'b0;
            clb_in_q  <= 1'b0;
            conn_en_q <= 1'b0;
            conn_in_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CFG_CRC_EN
            crc_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rem_q     <= rem_d;
            left_q    <= left_d;
            ready_q   <= ready_d;
            clb_en_q  <= clb_en_d;
            clb_in_q  <= clb_in_d;
            conn_en_q <= conn_en_d;
            conn_in_q <= conn_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CFG_CRC_EN
            crc_q     <= crc_d;
            err_q     <= err_d;
`endif
        end
    end

    assign cfg_ready    = ready_q;
    assign clb_scan_en  = clb_en_q;
    assign clb_scan_in  = clb_in_q;
    assign conn_scan_en = conn_en_q;
    assign conn_scan_in = conn_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef CFG_CRC_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

endmodule
